// File: rtl/echo_tap_ctrl_pkg.sv
// Shared types and helpers for the multi-tap echo delay-line controller.
// Holds the FSM encoding, default sizes and delay-address arithmetic.
package echo_tap_ctrl_pkg;

  localparam int DW_DEF    = 12;
  localparam int AW_DEF    = 16;
  localparam int DEPTH_DEF = 40000;
  localparam int NTAPS_DEF = 2;

  typedef enum logic [2:0] {
    IDLE,
    WRITE,
    READ,
    FLUSH,
    DONE
  } state_t;

  function automatic logic [31:0] clamp_delay(
    input logic [31:0] d,
    input logic [31:0] depth
  );
    return (d > depth - 1) ? depth - 1 : d;
  endfunction

  // Circular "p - d" over a buffer of depth entries; d is already clamped.
  function automatic logic [31:0] wrap_sub(
    input logic [31:0] p,
    input logic [31:0] d,
    input logic [31:0] depth
  );
    return (p >= d) ? p - d : p + depth - d;
  endfunction

endpackage

// File: rtl/echo_tap_ctrl.sv
// Multi-tap delay-line sequencer for one shared single-port sample RAM.
// Per tick: one write, NTAPS reads, then a single taps_valid pulse.
module echo_tap_ctrl
  import echo_tap_ctrl_pkg::*;
#(
  parameter int DW    = DW_DEF,
  parameter int AW    = AW_DEF,
  parameter int DEPTH = DEPTH_DEF,
  parameter int NTAPS = NTAPS_DEF
) (
  input  logic              CLOCK,
  input  logic              RESET,
  input  logic              sample_tick,
  input  logic [DW-1:0]     data_in,
  input  logic [NTAPS*AW-1:0] tap_delay,
  output logic [AW-1:0]     mem_addr,
  output logic              mem_we,
  output logic [DW-1:0]     mem_wdata,
  input  logic [DW-1:0]     mem_rdata,
  output logic [NTAPS*DW-1:0] taps_out,
  output logic              taps_valid,
  output logic              busy,
  output logic              overrun
);

  localparam int KW = (NTAPS > 1) ? $clog2(NTAPS) : 1;
  localparam logic [AW:0]   FULL = (AW+1)'(DEPTH);
  localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

  state_t              state, state_d;
  logic [KW-1:0]       k, k_d;
  logic [AW-1:0]       wr_ptr;
  logic [AW:0]         fill;
  logic [NTAPS*AW-1:0] dly, dly_clamp;
  logic [NTAPS*DW-1:0] tap_buf;
  logic                we_d;
  logic [AW-1:0]       addr_d;
  logic [DW-1:0]       wdata_d;
  logic                cap_en;
  int                  cap_idx;
  int                  rd_idx;
  logic [DW-1:0]       cap_val;

  assign busy = (state != IDLE);

  always_comb begin
    dly_clamp = '0;
    for (int i = 0; i < NTAPS; i++) begin
      dly_clamp[i*AW +: AW] =
        AW'(clamp_delay(32'(tap_delay[i*AW +: AW]), 32'(DEPTH)));
    end
  end

  always_comb begin
    state_d = state;
    k_d     = k;
    we_d    = 1'b0;
    addr_d  = mem_addr;
    wdata_d = mem_wdata;
    rd_idx  = 0;
    unique case (state)
      IDLE: begin
        if (sample_tick) begin
          state_d = WRITE;
          we_d    = 1'b1;
          addr_d  = wr_ptr;
          wdata_d = data_in;
        end
      end
      WRITE: begin
        state_d = READ;
        k_d     = '0;
        addr_d  = AW'(wrap_sub(32'(wr_ptr),
                               32'(dly[0 +: AW]), 32'(DEPTH)));
      end
      READ: begin
        if (k == KW'(NTAPS - 1)) begin
          state_d = FLUSH;
        end else begin
          k_d    = k + 1'b1;
          rd_idx = int'(k) + 1;
          addr_d = AW'(wrap_sub(32'(wr_ptr),
                                32'(dly[rd_idx*AW +: AW]), 32'(DEPTH)));
        end
      end
      FLUSH:   state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Read data lags its address by one cycle, so READ k lands tap k-1.
  always_comb begin
    cap_en  = 1'b0;
    cap_idx = 0;
    if (state == FLUSH) begin
      cap_en  = 1'b1;
      cap_idx = NTAPS - 1;
    end else if (state == READ && k != '0) begin
      cap_en  = 1'b1;
      cap_idx = int'(k) - 1;
    end
    cap_val = ({1'b0, dly[cap_idx*AW +: AW]} >= fill) ? '0 : mem_rdata;
  end

  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) begin
      state      <= IDLE;
      k          <= '0;
      wr_ptr     <= '0;
      fill       <= '0;
      dly        <= '0;
      tap_buf    <= '0;
      mem_addr   <= '0;
      mem_we     <= 1'b0;
      mem_wdata  <= '0;
      taps_out   <= '0;
      taps_valid <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      state      <= state_d;
      k          <= k_d;
      mem_we     <= we_d;
      mem_addr   <= addr_d;
      mem_wdata  <= wdata_d;
      taps_valid <= (state == FLUSH);
      if (state == IDLE && sample_tick) dly <= dly_clamp;
      if (state == WRITE && fill != FULL) fill <= fill + 1'b1;
      if (cap_en && state != FLUSH) begin
        tap_buf[cap_idx*DW +: DW] <= cap_val;
      end
      if (state == FLUSH) begin
        taps_out <= tap_buf;
        taps_out[(NTAPS-1)*DW +: DW] <= cap_val;
      end
      if (state == DONE) begin
        wr_ptr <= (wr_ptr == LAST) ? '0 : wr_ptr + 1'b1;
      end
      if (sample_tick && state != IDLE) overrun <= 1'b1;
    end
  end

endmodule

// File: tb/tb_echo_tap_ctrl.sv
// Self-checking bench for echo_tap_ctrl with a behavioural RAM and
// a sample-history reference model (DEPTH=8, NTAPS=2).
module tb_echo_tap_ctrl;

  localparam int DW = 12;
  localparam int AW = 16;
  localparam int DEPTH = 8;
  localparam int NTAPS = 2;

  logic CLOCK = 1'b0;
  logic RESET;
  logic sample_tick;
  logic [DW-1:0] data_in;
  logic [NTAPS*AW-1:0] tap_delay;
  logic [AW-1:0] mem_addr;
  logic mem_we;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic [NTAPS*DW-1:0] taps_out;
  logic taps_valid;
  logic busy;
  logic overrun;

  int total = 0;
  int bad = 0;

  logic [DW-1:0] ram [DEPTH];
  logic [DW-1:0] hist [$];
  int nwr;

  echo_tap_ctrl #(
    .DW(DW), .AW(AW), .DEPTH(DEPTH), .NTAPS(NTAPS)
  ) dut (
    .CLOCK(CLOCK),
    .RESET(RESET),
    .sample_tick(sample_tick),
    .data_in(data_in),
    .tap_delay(tap_delay),
    .mem_addr(mem_addr),
    .mem_we(mem_we),
    .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata),
    .taps_out(taps_out),
    .taps_valid(taps_valid),
    .busy(busy),
    .overrun(overrun)
  );

  always #5 CLOCK = ~CLOCK;

  always @(posedge CLOCK) begin
    mem_rdata <= ram[mem_addr[2:0]];
    if (mem_we) ram[mem_addr[2:0]] = mem_wdata;
  end

  // Expected tap for delay d, given the history after the latest write.
  function automatic logic [DW-1:0] exp_tap(input int d);
    int dc;
    int n;
    int f;
    dc = (d > DEPTH - 1) ? DEPTH - 1 : d;
    n = hist.size();
    f = (n > DEPTH) ? DEPTH : n;
    if (dc < f) return hist[n-1-dc];
    return '0;
  endfunction

  task automatic apply_reset();
    @(negedge CLOCK);
    RESET = 1'b1;
    sample_tick = 1'b0;
    @(negedge CLOCK);
    @(negedge CLOCK);
    RESET = 1'b0;
    hist.delete();
    nwr = 0;
  endtask

  task automatic do_tick(
    input logic [DW-1:0] d,
    input int d0, input int d1,
    input int m0, input int m1,
    output logic [DW-1:0] o0, output logic [DW-1:0] o1,
    output int lat, output int npulse,
    output logic [AW-1:0] waddr, output logic wwe
  );
    @(negedge CLOCK);
    sample_tick = 1'b1;
    data_in = d;
    tap_delay = {AW'(d1), AW'(d0)};
    @(negedge CLOCK);
    sample_tick = 1'b0;
    tap_delay = {AW'(m1), AW'(m0)};
    waddr = mem_addr;
    wwe = mem_we;
    lat = -1;
    npulse = 0;
    o0 = '0;
    o1 = '0;
    for (int c = 2; c <= 9; c++) begin
      @(negedge CLOCK);
      if (taps_valid) begin
        npulse++;
        if (lat < 0) begin
          lat = c;
          o0 = taps_out[DW-1:0];
          o1 = taps_out[2*DW-1:DW];
        end
      end
    end
    hist.push_back(d);
    nwr++;
  endtask

  task automatic test_reset();
    @(negedge CLOCK);
    RESET = 1'b1;
    #1;
    total++;
    if ({mem_addr, mem_we, mem_wdata, taps_out, taps_valid, busy, overrun}
        !== '0) begin
      bad++;
      $display("FAIL reset_outputs got addr=%0h we=%0b wd=%0h taps=%0h v=%0b busy=%0b ovr=%0b exp all 0",
               mem_addr, mem_we, mem_wdata, taps_out, taps_valid, busy, overrun);
    end
    apply_reset();
  endtask

  task automatic test_first_tick();
    logic [DW-1:0] o0, o1;
    int lat, np;
    logic [AW-1:0] wa;
    logic we;
    do_tick(12'h123, 0, 3, 0, 3, o0, o1, lat, np, wa, we);
    total++;
    if (lat !== 5) begin
      bad++; $display("FAIL first_latency got=%0d exp=5", lat);
    end
    total++;
    if (o0 !== 12'h123) begin
      bad++; $display("FAIL first_tap0 got=%0h exp=123", o0);
    end
    total++;
    if (o1 !== 12'h000) begin
      bad++; $display("FAIL first_tap1 got=%0h exp=0", o1);
    end
    total++;
    if (wa !== 16'd0 || we !== 1'b1) begin
      bad++; $display("FAIL first_write got addr=%0d we=%0b exp addr=0 we=1", wa, we);
    end
  endtask

  task automatic test_wrap();
    logic [DW-1:0] o0, o1;
    int lat, np;
    logic [AW-1:0] wa;
    logic we;
    apply_reset();
    for (int i = 1; i <= 10; i++) begin
      do_tick(DW'(i), 0, 7, 0, 7, o0, o1, lat, np, wa, we);
      total++;
      if (o1 !== exp_tap(7) || o0 !== exp_tap(0)) begin
        bad++;
        $display("FAIL wrap_taps i=%0d got=%0h/%0h exp=%0h/%0h",
                 i, o0, o1, exp_tap(0), exp_tap(7));
      end
    end
    total++;
    if (o0 !== 12'd10 || o1 !== 12'd3) begin
      bad++; $display("FAIL wrap_tenth got=%0d/%0d exp=10/3", o0, o1);
    end
    total++;
    if (wa !== 16'd1) begin
      bad++; $display("FAIL wrap_addr10 got=%0d exp=1", wa);
    end
  endtask

  task automatic test_clamp();
    logic [DW-1:0] o0, o1;
    int lat, np;
    logic [AW-1:0] wa;
    logic we;
    do_tick(12'd11, 0, 9, 0, 9, o0, o1, lat, np, wa, we);
    total++;
    if (wa !== 16'd2) begin
      bad++; $display("FAIL clamp_wrptr got=%0d exp=2", wa);
    end
    total++;
    if (o1 !== 12'd4 || o1 !== exp_tap(7)) begin
      bad++; $display("FAIL clamp_tap1 got=%0d exp=4", o1);
    end
    total++;
    if (o0 !== 12'd11) begin
      bad++; $display("FAIL clamp_tap0 got=%0d exp=11", o0);
    end
  endtask

  task automatic test_overrun();
    logic [DW-1:0] o0, o1, first;
    int lat, np;
    logic [AW-1:0] wa;
    logic we;
    total++;
    if (overrun !== 1'b0) begin
      bad++; $display("FAIL overrun_idle got=%0b exp=0", overrun);
    end
    first = DW'($urandom_range(1, 4095));
    @(negedge CLOCK);
    sample_tick = 1'b1;
    data_in = first;
    tap_delay = {16'd1, 16'd0};
    @(negedge CLOCK);
    sample_tick = 1'b0;
    @(negedge CLOCK);
    sample_tick = 1'b1;
    data_in = ~first;
    @(negedge CLOCK);
    sample_tick = 1'b0;
    np = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge CLOCK);
      if (taps_valid) begin
        np++;
        o0 = taps_out[DW-1:0];
      end
    end
    hist.push_back(first);
    nwr++;
    total++;
    if (overrun !== 1'b1) begin
      bad++; $display("FAIL overrun_set got=%0b exp=1", overrun);
    end
    total++;
    if (np !== 1) begin
      bad++; $display("FAIL overrun_pulses got=%0d exp=1", np);
    end
    total++;
    if (o0 !== first) begin
      bad++; $display("FAIL overrun_tap0 got=%0h exp=%0h", o0, first);
    end
    do_tick(12'h5a5, 0, 1, 0, 1, o0, o1, lat, np, wa, we);
    total++;
    if (wa !== AW'(nwr - 1) % AW'(DEPTH) || wa !== 16'd4) begin
      bad++; $display("FAIL overrun_wrptr got=%0d exp=4", wa);
    end
    total++;
    if (o1 !== first || overrun !== 1'b1) begin
      bad++;
      $display("FAIL overrun_after got tap1=%0h ovr=%0b exp tap1=%0h ovr=1",
               o1, overrun, first);
    end
  endtask

  task automatic test_reset_mid();
    logic [DW-1:0] o0, o1;
    int lat, np;
    logic [AW-1:0] wa;
    logic we;
    @(negedge CLOCK);
    sample_tick = 1'b1;
    data_in = 12'h777;
    tap_delay = {16'd1, 16'd0};
    @(negedge CLOCK);
    sample_tick = 1'b0;
    @(negedge CLOCK);
    RESET = 1'b1;
    #1;
    total++;
    if ({mem_addr, mem_we, mem_wdata, taps_out, taps_valid, busy, overrun}
        !== '0) begin
      bad++;
      $display("FAIL midreset_outputs got addr=%0h we=%0b taps=%0h busy=%0b ovr=%0b exp all 0",
               mem_addr, mem_we, taps_out, busy, overrun);
    end
    @(negedge CLOCK);
    RESET = 1'b0;
    hist.delete();
    nwr = 0;
    np = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge CLOCK);
      if (taps_valid) np++;
    end
    total++;
    if (np !== 0) begin
      bad++; $display("FAIL midreset_pulses got=%0d exp=0", np);
    end
    do_tick(12'h0ab, 0, 1, 0, 1, o0, o1, lat, np, wa, we);
    total++;
    if (o1 !== 12'h000 || o0 !== 12'h0ab || wa !== 16'd0) begin
      bad++;
      $display("FAIL midreset_next got=%0h/%0h addr=%0d exp=ab/0 addr=0",
               o0, o1, wa);
    end
  endtask

  task automatic test_random();
    logic [DW-1:0] o0, o1, d;
    int lat, np, d0, d1;
    logic [AW-1:0] wa;
    logic we;
    for (int i = 0; i < 40; i++) begin
      d = DW'($urandom);
      d0 = $urandom_range(0, 11);
      d1 = $urandom_range(0, 11);
      do_tick(d, d0, d1, d0, d1, o0, o1, lat, np, wa, we);
      total++;
      if (o0 !== exp_tap(d0) || o1 !== exp_tap(d1)) begin
        bad++;
        $display("FAIL rand_taps i=%0d d=%0d/%0d got=%0h/%0h exp=%0h/%0h",
                 i, d0, d1, o0, o1, exp_tap(d0), exp_tap(d1));
      end
      total++;
      if (lat !== 5 || np !== 1) begin
        bad++; $display("FAIL rand_pulse i=%0d got lat=%0d n=%0d exp lat=5 n=1", i, lat, np);
      end
      total++;
      if (wa !== AW'((nwr - 1) % DEPTH) || we !== 1'b1) begin
        bad++;
        $display("FAIL rand_waddr i=%0d got=%0d we=%0b exp=%0d we=1",
                 i, wa, we, (nwr - 1) % DEPTH);
      end
    end
  endtask

  task automatic test_delay_change();
    logic [DW-1:0] o0, o1;
    int lat, np;
    logic [AW-1:0] wa;
    logic we;
    do_tick(12'h3c3, 2, 6, 5, 1, o0, o1, lat, np, wa, we);
    total++;
    if (o0 !== exp_tap(2) || o1 !== exp_tap(6)) begin
      bad++;
      $display("FAIL dchange_old got=%0h/%0h exp=%0h/%0h",
               o0, o1, exp_tap(2), exp_tap(6));
    end
    do_tick(12'h4d4, 5, 1, 5, 1, o0, o1, lat, np, wa, we);
    total++;
    if (o0 !== exp_tap(5) || o1 !== exp_tap(1) || o1 !== 12'h3c3) begin
      bad++;
      $display("FAIL dchange_new got=%0h/%0h exp=%0h/%0h",
               o0, o1, exp_tap(5), exp_tap(1));
    end
  endtask

  initial begin
    RESET = 1'b1;
    sample_tick = 1'b0;
    data_in = '0;
    tap_delay = '0;
    nwr = 0;
    for (int i = 0; i < DEPTH; i++) ram[i] = DW'($urandom_range(1, 4095));
    test_reset();
    test_first_tick();
    test_wrap();
    test_clamp();
    test_overrun();
    test_reset_mid();
    test_random();
    test_delay_change();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
